cpu_operand_fetch: RTL and testbench

//  Issue stage directly upstream of the register bank. Accepts decoded instructions, drives the bank's
//  two read addresses, and returns both operands one cycle later (bank read latency is 1 cycle).
//  The bank returns the pre-write value when a read and a write hit the same address on the same edge;

---
 rtl/cpu_operand_fetch.sv | 144 ++++++++++++++
 tb/tb_cpu_operand_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_operand_fetch.sv
// Operand fetch stage: drives register-bank read addresses, forwards same-edge writebacks,
// stalls RAW/WAW hazards with a busy-bit scoreboard and holds its output under backpressure.
module cpu_operand_fetch #(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = $clog2(NUM_REGS),
  parameter int PAYLOAD_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_src_a,
  input  logic [REG_ADDR_W-1:0] in_src_b,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic                  in_dst_en,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  output logic [REG_ADDR_W-1:0] rf_read_reg_a,
  output logic [REG_ADDR_W-1:0] rf_read_reg_b,
  input  logic [REG_WIDTH-1:0]  rf_read_data_a,
  input  logic [REG_WIDTH-1:0]  rf_read_data_b,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [REG_WIDTH-1:0]  wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_WIDTH-1:0]  out_op_a,
  output logic [REG_WIDTH-1:0]  out_op_b,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  out_dst_en,
  output logic [PAYLOAD_W-1:0]  out_payload
);

  // state | meaning
  // EMPTY | no entry on the output
  // FRESH | entry valid, operands from bank read data (or forwarded value)
  // HOLD  | entry stalled by consumer, operands from hold registers
  typedef enum logic [1:0] {EMPTY, FRESH, HOLD} state_t;

  state_t                state_q, state_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  fwd_flag_a, fwd_flag_b;
  logic [REG_WIDTH-1:0]  fwd_a, fwd_b;
  logic [REG_WIDTH-1:0]  hold_a, hold_b;
  logic [REG_WIDTH-1:0]  mux_a, mux_b;
  logic                  hit_a, hit_b, hit_d;
  logic                  hazard, slot_free, accept, capture_hold;

  assign rf_read_reg_a = in_src_a;
  assign rf_read_reg_b = in_src_b;

  assign hit_a = wb_valid && (wb_reg == in_src_a);
  assign hit_b = wb_valid && (wb_reg == in_src_b);
  assign hit_d = wb_valid && (wb_reg == in_dst);

  // A writeback landing on the same edge releases the hazard; forwarding covers the stale bank read.
  assign hazard = (busy_q[in_src_a] && !hit_a)
               || (busy_q[in_src_b] && !hit_b)
               || (in_dst_en && busy_q[in_dst] && !hit_d);

  assign slot_free = (state_q == EMPTY) || out_ready;
  assign in_ready  = slot_free && !hazard;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != EMPTY);

  assign mux_a = fwd_flag_a ? fwd_a : rf_read_data_a;
  assign mux_b = fwd_flag_b ? fwd_b : rf_read_data_b;

  always_comb begin
    out_op_a = '0;
    out_op_b = '0;
    case (state_q)
      FRESH: begin
        out_op_a = mux_a;
        out_op_b = mux_b;
      end
      HOLD: begin
        out_op_a = hold_a;
        out_op_b = hold_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    capture_hold = 1'b0;
    case (state_q)
      EMPTY: if (accept) state_d = FRESH;
      FRESH, HOLD: begin
        if (out_ready) begin
          state_d = accept ? FRESH : EMPTY;
        end else if (state_q == FRESH) begin
          state_d      = HOLD;
          capture_hold = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Set beats clear when an issue and a writeback target the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_reg] = 1'b0;
    if (accept && in_dst_en) busy_d[in_dst] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      busy_q      <= '0;
      fwd_flag_a  <= 1'b0;
      fwd_flag_b  <= 1'b0;
      fwd_a       <= '0;
      fwd_b       <= '0;
      hold_a      <= '0;
      hold_b      <= '0;
      out_dst     <= '0;
      out_dst_en  <= 1'b0;
      out_payload <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (capture_hold) begin
        hold_a <= mux_a;
        hold_b <= mux_b;
      end
      if (accept) begin
        fwd_flag_a  <= hit_a;
        fwd_flag_b  <= hit_b;
        fwd_a       <= wb_data;
        fwd_b       <= wb_data;
        out_dst     <= in_dst;
        out_dst_en  <= in_dst_en;
        out_payload <= in_payload;
      end else if (state_d == EMPTY) begin
        fwd_flag_a <= 1'b0;
        fwd_flag_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Self-checking bench for cpu_operand_fetch: table-driven issue stream plus hand-written
// hazard, forwarding, backpressure and reset sequences against a 1-cycle-latency bank model.
module tb_cpu_operand_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_src_a, in_src_b, in_dst;
  logic        in_dst_en;
  logic [31:0] in_payload;
  logic [3:0]  rf_read_reg_a, rf_read_reg_b;
  logic [31:0] rf_read_data_a, rf_read_data_b;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b;
  logic [3:0]  out_dst;
  logic        out_dst_en;
  logic [31:0] out_payload;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] bank [16];

  always #5 clock = ~clock;

  cpu_operand_fetch dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst), .in_dst_en(in_dst_en),
    .in_payload(in_payload),
    .rf_read_reg_a(rf_read_reg_a), .rf_read_reg_b(rf_read_reg_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dst(out_dst), .out_dst_en(out_dst_en),
    .out_payload(out_payload)
  );

  // Bank: registered read returning the pre-write value on a same-edge write.
  always @(posedge clock) begin
    rf_read_data_a <= bank[rf_read_reg_a];
    rf_read_data_b <= bank[rf_read_reg_b];
    if (reset) begin
      for (int i = 0; i < 16; i++) bank[i] <= 32'hA0 + i;
      bank[3] <= 32'h11;
      bank[4] <= 32'h22;
    end else if (wb_valid) begin
      bank[wb_reg] <= wb_data;
    end
  end

  typedef struct {
    logic [3:0]  sa, sb, dst;
    logic [31:0] pay, ea, eb;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] d, input logic en, input logic [31:0] pay);
    in_valid   = v;
    in_src_a   = sa;
    in_src_b   = sb;
    in_dst     = d;
    in_dst_en  = en;
    in_payload = pay;
  endtask

  task automatic set_wb(input logic v, input logic [3:0] r, input logic [31:0] d);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
  endtask

  initial begin
    vecs[0] = '{sa: 4'd3,  sb: 4'd4,  dst: 4'd1,  pay: 32'h100, ea: 32'h11, eb: 32'h22};
    vecs[1] = '{sa: 4'd0,  sb: 4'd15, dst: 4'd2,  pay: 32'h101, ea: 32'hA0, eb: 32'hAF};
    vecs[2] = '{sa: 4'd5,  sb: 4'd6,  dst: 4'd3,  pay: 32'h102, ea: 32'hA5, eb: 32'hA6};
    vecs[3] = '{sa: 4'd7,  sb: 4'd7,  dst: 4'd4,  pay: 32'h103, ea: 32'hA7, eb: 32'hA7};
    vecs[4] = '{sa: 4'd8,  sb: 4'd9,  dst: 4'd5,  pay: 32'h104, ea: 32'hA8, eb: 32'hA9};
    vecs[5] = '{sa: 4'd10, sb: 4'd11, dst: 4'd6,  pay: 32'h105, ea: 32'hAA, eb: 32'hAB};
    vecs[6] = '{sa: 4'd12, sb: 4'd13, dst: 4'd7,  pay: 32'h106, ea: 32'hAC, eb: 32'hAD};
    vecs[7] = '{sa: 4'd14, sb: 4'd1,  dst: 4'd8,  pay: 32'h107, ea: 32'hAE, eb: 32'hA1};

    reset     = 1'b1;
    out_ready = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0);
    set_wb(1'b0, 4'd0, 32'h0);
    repeat (3) step();
    reset = 1'b0;
    #1;

    chk("rst_out_valid",   {31'b0, out_valid},  32'h0);
    chk("rst_op_a",        out_op_a,            32'h0);
    chk("rst_op_b",        out_op_b,            32'h0);
    chk("rst_dst",         {28'b0, out_dst},    32'h0);
    chk("rst_dst_en",      {31'b0, out_dst_en}, 32'h0);
    chk("rst_payload",     out_payload,         32'h0);
    chk("rst_in_ready",    {31'b0, in_ready},   32'h1);

    // Back-to-back independent issues, one output per cycle.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, vecs[i].sa, vecs[i].sb, vecs[i].dst, 1'b0, vecs[i].pay);
      #1;
      chk("tbl_in_ready", {31'b0, in_ready}, 32'h1);
      step();
      chk("tbl_out_valid", {31'b0, out_valid}, 32'h1);
      chk("tbl_op_a",      out_op_a,           vecs[i].ea);
      chk("tbl_op_b",      out_op_b,           vecs[i].eb);
      chk("tbl_dst",       {28'b0, out_dst},   {28'b0, vecs[i].dst});
      chk("tbl_payload",   out_payload,        vecs[i].pay);
    end
    in_valid = 1'b0;
    step();
    chk("tbl_drain", {31'b0, out_valid}, 32'h0);

    // RAW stall released by a same-cycle writeback, value forwarded.
    set_in(1'b1, 4'd0, 4'd1, 4'd5, 1'b1, 32'h200);
    #1;
    step();
    chk("t2_dst_en", {31'b0, out_dst_en}, 32'h1);
    set_in(1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 32'h201);
    #1;
    chk("t2_raw_stall0", {31'b0, in_ready}, 32'h0);
    step();
    chk("t2_raw_stall1", {31'b0, in_ready}, 32'h0);
    step();
    set_wb(1'b1, 4'd5, 32'hAB);
    #1;
    chk("t2_wb_release", {31'b0, in_ready}, 32'h1);
    step();
    set_wb(1'b0, 4'd0, 32'h0);
    chk("t2_out_valid", {31'b0, out_valid}, 32'h1);
    chk("t2_fwd_op_a",  out_op_a,           32'hAB);
    chk("t2_op_b",      out_op_b,           32'hA0);
    in_valid = 1'b0;
    step();

    // Backpressure: outputs hold while bank data under them changes.
    set_in(1'b1, 4'd6, 4'd8, 4'd0, 1'b0, 32'h300);
    #1;
    step();
    out_ready = 1'b0;
    set_in(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 32'h301);
    set_wb(1'b1, 4'd7, 32'h77);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_in_ready", {31'b0, in_ready},  32'h0);
      chk("t3_valid",    {31'b0, out_valid}, 32'h1);
      chk("t3_op_a",     out_op_a,           32'hA6);
      chk("t3_op_b",     out_op_b,           32'hA8);
      chk("t3_payload",  out_payload,        32'h300);
      step();
    end
    set_wb(1'b0, 4'd0, 32'h0);
    chk("t3_hold_op_a", out_op_a, 32'hA6);
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("t3_next_valid",   {31'b0, out_valid}, 32'h1);
    chk("t3_next_op_a",    out_op_a,           32'hA1);
    chk("t3_next_op_b",    out_op_b,           32'hA2);
    chk("t3_next_payload", out_payload,        32'h301);
    in_valid = 1'b0;
    step();
    chk("t3_empty", {31'b0, out_valid}, 32'h0);

    // Same-cycle writeback and re-issue to r2: set wins over clear.
    set_in(1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 32'h500);
    #1;
    step();
    set_in(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 32'h501);
    set_wb(1'b1, 4'd2, 32'h55);
    #1;
    chk("t5_waw_wbhit", {31'b0, in_ready}, 32'h1);
    step();
    set_wb(1'b0, 4'd0, 32'h0);
    set_in(1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 32'h502);
    #1;
    chk("t5_busy_stall0", {31'b0, in_ready}, 32'h0);
    step();
    chk("t5_busy_stall1", {31'b0, in_ready}, 32'h0);
    set_wb(1'b1, 4'd2, 32'h66);
    #1;
    chk("t5_release", {31'b0, in_ready}, 32'h1);
    step();
    set_wb(1'b0, 4'd0, 32'h0);
    chk("t5_fwd_op_a", out_op_a, 32'h66);
    in_valid = 1'b0;
    step();

    // Reset while holding with r9 busy.
    set_in(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 32'h600);
    #1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    chk("t6_hold_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_reset_drop", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b1;
    set_in(1'b1, 4'd9, 4'd3, 4'd0, 1'b0, 32'h601);
    #1;
    chk("t6_issue_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("t6_op_a", out_op_a, 32'hA9);
    chk("t6_op_b", out_op_b, 32'h11);
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
